// File: rtl/spi_word_slave_rx.sv
// rtl/spi_word_slave_rx.sv - SPI mode-0 word receiver, pins oversampled into i_Clk.
// Optional MISO return path enabled by SPI_SLAVE_MISO_EN.
module spi_word_slave_rx #(
    parameter int WORD_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_SPI_Clk,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO,
    input  logic [WORD_WIDTH-1:0] i_TX_Word,
    output logic [WORD_WIDTH-1:0] o_RX_Word,
    output logic                  o_RX_DV,
    output logic                  o_Frame_Err,
    output logic [CNT_WIDTH-1:0]  o_Word_Count,
    output logic                  o_Busy
);
    localparam int BIT_W = $clog2(WORD_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic sclk_s1, sclk_s2, sclk_h;
    logic cs_s1, cs_s2, cs_h;
    logic mosi_s1, mosi_s2;

    logic [BIT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-2:0] shift_reg;
    logic [WORD_WIDTH-1:0] shift_next;

    logic sclk_rise, cs_fall, cs_rise;
    logic frame_start, frame_end, bit_en, word_done;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_h <= 1'b0;
            cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_h   <= 1'b1;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= i_SPI_Clk;  sclk_s2 <= sclk_s1; sclk_h <= sclk_s2;
            cs_s1   <= i_SPI_CS_n; cs_s2   <= cs_s1;   cs_h   <= cs_s2;
            mosi_s1 <= i_SPI_MOSI; mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_h;
    assign cs_fall   = ~cs_s2 & cs_h;
    assign cs_rise   = cs_s2 & ~cs_h;
    assign o_Busy    = ~cs_s2;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= IDLE;
        else          state <= state_next;
    end

    // A CS_n edge in the same cycle as an SCLK edge takes priority.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        bit_en      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else if (!cs_fall) begin
                    bit_en = sclk_rise;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign word_done  = bit_en && (bit_cnt == LAST_BIT);
    assign shift_next = {shift_reg, mosi_s2};

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            o_RX_Word    <= '0;
            o_RX_DV      <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Word_Count <= '0;
        end else begin
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            if (frame_start) begin
                bit_cnt      <= '0;
                o_Word_Count <= '0;
            end else if (frame_end) begin
                if (bit_cnt != '0) o_Frame_Err <= 1'b1;
                bit_cnt <= '0;
            end else if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (bit_en) begin
                shift_reg <= shift_next[WORD_WIDTH-2:0];
                if (word_done) begin
                    o_RX_Word <= shift_next;
                    o_RX_DV   <= 1'b1;
                    bit_cnt   <= '0;
                    if (o_Word_Count != '1) o_Word_Count <= o_Word_Count + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_MISO_EN
    logic [WORD_WIDTH-1:0] tx_shift;
    logic                  skip_fall;
    logic                  sclk_fall;

    assign sclk_fall = ~sclk_s2 & sclk_h;

    // A word completes while SCLK is still high; the falling edge that follows
    // must present the freshly loaded MSB rather than shift it away.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_shift  <= '0;
            skip_fall <= 1'b0;
        end else if (frame_start) begin
            tx_shift  <= i_TX_Word;
            skip_fall <= 1'b0;
        end else if (word_done) begin
            tx_shift  <= i_TX_Word;
            skip_fall <= 1'b1;
        end else if (state == ACTIVE && !cs_rise && sclk_fall) begin
            if (skip_fall) skip_fall <= 1'b0;
            else           tx_shift  <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
        end
    end

    assign o_SPI_MISO = (state == ACTIVE) ? tx_shift[WORD_WIDTH-1] : 1'b0;
`else
    logic unused_tx;
    assign unused_tx  = ^i_TX_Word;
    assign o_SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_slave_rx.sv
// tb/tb_spi_word_slave_rx.sv - directed vector bench for spi_word_slave_rx.
module tb_spi_word_slave_rx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk, cs_n, mosi, miso;
    logic [15:0] tx_word, rx_word;
    logic        rx_dv, frame_err, busy;
    logic [7:0]  word_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise = 0;
    int fe_cnt = 0;
    int dv_lat_bad = 0;
    int dv_wide = 0;
    logic dv_prev = 1'b0;
    logic [15:0] rx_q[$];

    spi_word_slave_rx #(.WORD_WIDTH(16), .CNT_WIDTH(8)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sclk), .i_SPI_CS_n(cs_n),
        .i_SPI_MOSI(mosi), .o_SPI_MISO(miso), .i_TX_Word(tx_word),
        .o_RX_Word(rx_word), .o_RX_DV(rx_dv), .o_Frame_Err(frame_err),
        .o_Word_Count(word_count), .o_Busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_dv) begin
            rx_q.push_back(rx_word);
            if (cyc - last_rise != 3) dv_lat_bad++;
        end
        if (rx_dv && dv_prev) dv_wide++;
        dv_prev = rx_dv;
        if (frame_err) fe_cnt++;
    end

    typedef struct {
        logic [15:0] mosi_word;
        logic [15:0] tx;
        logic [15:0] exp_rx;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [15:0] exp_miso(input logic [15:0] tx);
`ifdef SPI_SLAVE_MISO_EN
        return tx;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(1);
        check("busy_lat1", busy, 1'b0);
        tick(1);
        check("busy_lat2", busy, 1'b1);
        tick(4);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, output logic [15:0] m);
        m = 16'h0;
        for (int i = 0; i < n; i++) begin
            mosi = w[15-i];
            tick(4);
            m[15-i] = miso;
            sclk = 1'b1;
            last_rise = cyc;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_end();
        tick(4);
        cs_n = 1'b1;
        tick(8);
        check("busy_idle", busy, 1'b0);
    endtask

    logic [15:0] m;
    logic [15:0] b2b[3];
    int fe0;

    initial begin
        vecs[0] = '{16'hA5C3, 16'hBEEF, 16'hA5C3};
        vecs[1] = '{16'h1357, 16'hBEEF, 16'h1357};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[4] = '{16'h1234, 16'h8001, 16'h1234};
        b2b[0] = 16'h0001; b2b[1] = 16'h8000; b2b[2] = 16'hFFFF;

        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_word = 16'h0;
        tick(5);
        check("rst_rx_word", rx_word, 16'h0);
        check("rst_rx_dv", rx_dv, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_word_count", word_count, 8'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", miso, 1'b0);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_no_dv", rx_q.size(), 0);
        check("post_rst_no_fe", fe_cnt, 0);

        for (int v = 0; v < 5; v++) begin
            rx_q.delete();
            fe0 = fe_cnt;
            tx_word = vecs[v].tx;
            frame_begin();
            send_bits(vecs[v].mosi_word, 16, m);
            frame_end();
            check("vec_dv_count", rx_q.size(), 1);
            if (rx_q.size() > 0) check("vec_dv_word", rx_q[0], vecs[v].exp_rx);
            check("vec_rx_word", rx_word, vecs[v].exp_rx);
            check("vec_word_count", word_count, 8'd1);
            check("vec_no_fe", fe_cnt - fe0, 0);
            check("vec_miso", m, exp_miso(vecs[v].tx));
        end

        rx_q.delete();
        fe0 = fe_cnt;
        tx_word = 16'hBEEF;
        frame_begin();
        for (int w = 0; w < 3; w++) begin
            send_bits(b2b[w], 16, m);
            check("b2b_miso", m, exp_miso(16'hBEEF));
        end
        frame_end();
        check("b2b_dv_count", rx_q.size(), 3);
        for (int w = 0; w < 3; w++)
            if (rx_q.size() > w) check("b2b_word", rx_q[w], b2b[w]);
        check("b2b_word_count", word_count, 8'd3);
        check("b2b_no_fe", fe_cnt - fe0, 0);

        rx_q.delete();
        fe0 = fe_cnt;
        frame_begin();
        send_bits(16'h0F0F, 9, m);
        frame_end();
        check("abort_fe", fe_cnt - fe0, 1);
        check("abort_no_dv", rx_q.size(), 0);
        check("abort_rx_hold", rx_word, 16'hFFFF);
        frame_begin();
        send_bits(16'h1234, 16, m);
        frame_end();
        check("after_abort_dv", rx_q.size(), 1);
        if (rx_q.size() > 0) check("after_abort_word", rx_q[0], 16'h1234);
        check("after_abort_fe", fe_cnt - fe0, 1);

        rx_q.delete();
        frame_begin();
        send_bits(16'hC3C3, 7, m);
        rst_n = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(3);
        check("midrst_rx_word", rx_word, 16'h0);
        check("midrst_count", word_count, 8'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_miso", miso, 1'b0);
        rst_n = 1'b1;
        tick(4);
        fe0 = fe_cnt;
        frame_begin();
        send_bits(16'h5A5A, 16, m);
        frame_end();
        check("midrst_dv_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("midrst_word", rx_q[0], 16'h5A5A);
        check("midrst_word_count", word_count, 8'd1);
        check("midrst_no_fe", fe_cnt - fe0, 0);

        check("dv_latency", dv_lat_bad, 0);
        check("dv_width", dv_wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_word_slave_rx.md
# spi_word_slave_rx

SPI mode-0 slave that receives the word stream driven by the team's SPI word master (CS_n, SCLK, MOSI) and recovers each word in the `i_Clk` domain. It is the receive end of the FPGA→Arduino sample link, used on a second board and in loop-back on the same board. All pin inputs are asynchronous to `i_Clk` and are oversampled. Optionally the block returns a word on MISO in the same frame.

## Interface
- `WORD_WIDTH`, 16, bits per word, MSB first; legal range 2..32.
- `CNT_WIDTH`, 8, width of the per-frame word counter.
- `i_Clk`  in  1  system clock (16 MHz on the board).
- `i_Rst_L`  in  1  reset, asynchronous, active-low.
- `i_SPI_Clk`  in  1  SCLK from the master; idle low (CPOL=0).
- `i_SPI_CS_n`  in  1  chip select, active-low.
- `i_SPI_MOSI`  in  1  serial data from the master.
- `o_SPI_MISO`  out  1  serial data to the master.
- `i_TX_Word`  in  WORD_WIDTH  word returned on MISO; sampled at load points.
- `o_RX_Word`  out  WORD_WIDTH  last complete received word; held until the next word completes.
- `o_RX_DV`  out  1  one-cycle pulse: `o_RX_Word` updated.
- `o_Frame_Err`  out  1  one-cycle pulse: CS_n rose with a partial word pending.
- `o_Word_Count`  out  CNT_WIDTH  complete words in the current or last frame; saturates at all-ones.
- `o_Busy`  out  1  high while the synchronized CS_n is low.

## Operation
- `i_SPI_Clk`, `i_SPI_CS_n` and `i_SPI_MOSI` each pass through two flops, then one history flop for edge detect.
  - All decisions use the stage-2 values. MOSI and SCLK therefore stay aligned.
  - Reset values: SCLK chain 0, CS_n chain 1, MOSI chain 0.
- State machine, two states:
  - IDLE: synchronized CS_n is high. The bit counter is held at 0.
  - ACTIVE: synchronized CS_n is low.
  - IDLE→ACTIVE on a CS_n falling edge. At this transition `o_Word_Count` clears to 0 and `bit_cnt` clears to 0.
  - ACTIVE→IDLE on a CS_n rising edge. If `bit_cnt`≠0, pulse `o_Frame_Err` and discard the partial word. `o_RX_DV` does not pulse.
- In ACTIVE, on each synchronized SCLK rising edge:
  - Shift the sampled MOSI into the LSB of the shift register.
  - Increment `bit_cnt`.
  - When `bit_cnt` reaches WORD_WIDTH-1 (the last bit), load `{shift[WORD_WIDTH-2:0], mosi}` into `o_RX_Word`, pulse `o_RX_DV`, wrap `bit_cnt` to 0, and increment `o_Word_Count` (saturating).
- Back-to-back words inside one frame are legal and unlimited.
- SCLK edges while CS_n is high are ignored.
- A CS_n edge and an SCLK edge detected in the same cycle: the CS_n edge wins and the SCLK edge is dropped.
- Reset values: `o_RX_Word`=0, `o_RX_DV`=0, `o_Frame_Err`=0, `o_Word_Count`=0, `o_Busy`=0, `o_SPI_MISO`=0. State is IDLE.
- Reset mid-frame: everything returns to reset values immediately. The block re-enters ACTIVE only on a new CS_n falling edge after reset release.

## Timing
- `o_RX_DV` rises after the 3rd `i_Clk` rising edge following the SCLK pin rising on the last bit. It is high for exactly 1 cycle.
- `o_Frame_Err` follows the same 3-edge latency, measured from the CS_n pin rising.
- `o_Busy` follows CS_n with 2 edges of latency.
- Master constraints:
  - SCLK high and low phases of at least 4 `i_Clk` cycles each.
  - At least 4 cycles from CS_n falling to the first SCLK rise.
  - At least 4 cycles from the last SCLK fall to CS_n rising.
  - Faster SCLK is out of spec, and behaviour under it is undefined.
- MISO (when enabled) changes only on a detected SCLK falling edge or at a load point. It is stable for ≥1 cycle before the master's next rising edge.

## Configuration
- Macro: `SPI_SLAVE_MISO_EN`.
- Defined:
  - Load points are the CS_n falling edge and each word completion inside a frame; at each, `i_TX_Word` is loaded into a TX shift register.
  - MSB is driven on `o_SPI_MISO` at the load point. The register shifts left on each synchronized SCLK falling edge.
  - `o_SPI_MISO` is 0 in IDLE.
- Not defined: `o_SPI_MISO` is constant 0, `i_TX_Word` is unused, and no TX register is synthesized.

## Test plan
- Reset held low for 5 cycles, no pin activity → all outputs at reset values. Release → `o_Busy`=0 and no pulses.
- One frame, one word 16'hA5C3, SCLK half-period 4 cycles → single `o_RX_DV`, `o_RX_Word`=16'hA5C3, `o_Word_Count`=1, no `o_Frame_Err`.
- One frame with back-to-back words 16'h0001, 16'h8000, 16'hFFFF → 3 DV pulses in order with those values, `o_Word_Count`=3.
- Frame aborted after 9 bits → one `o_Frame_Err`, no DV, `o_RX_Word` keeps its previous value. The next full frame with 16'h1234 is received correctly.
- `i_Rst_L` pulsed low after bit 7 of a word, then a fresh frame with 16'h5A5A → only 16'h5A5A is reported, with no stale bits.
- With `SPI_SLAVE_MISO_EN` and `i_TX_Word`=16'hBEEF → the master samples 16'hBEEF on MISO while sending 16'h1357. Without the macro, MISO reads 16'h0000.
